// File: rtl/riscv_pkg.sv
// riscv_pkg: shared opcodes, ALU op encoding and core state types. Rev 1.0
`default_nettype none

package riscv_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
  } alu_op_t;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } core_state_t;

  typedef enum logic [1:0] {
    HC_NONE       = 2'd0,
    HC_ILLEGAL    = 2'd1,
    HC_MISALIGNED = 2'd2,
    HC_RSVD       = 2'd3
  } halt_cause_t;

  // alt selects SUB for funct3=000 and SRA for funct3=101
  function automatic alu_op_t alu_op_from_funct3(input logic [2:0] f3, input logic alt);
    alu_op_t op;
    unique case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

`default_nettype wire

// File: rtl/riscv_alu.sv
// riscv_alu: combinational integer ALU with branch compare flags. Rev 1.0
`default_nettype none

module riscv_alu
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  alu_op_t             op,
  input  logic [XLEN-1:0]     a,
  input  logic [XLEN-1:0]     b,
  output logic [XLEN-1:0]     result,
  output logic                eq,
  output logic                lt,
  output logic                ltu
);

  localparam int SHW = (XLEN == 64) ? 6 : 5;

  logic [SHW-1:0] shamt;

  assign shamt = b[SHW-1:0];
  assign eq    = (a == b);
  assign lt    = ($signed(a) < $signed(b));
  assign ltu   = (a < b);

  always_comb begin
    result = '0;
    unique case (op)
      ALU_ADD:    result = a + b;
      ALU_SUB:    result = a - b;
      ALU_SLL:    result = a << shamt;
      ALU_SLT:    result = {{(XLEN-1){1'b0}}, lt};
      ALU_SLTU:   result = {{(XLEN-1){1'b0}}, ltu};
      ALU_XOR:    result = a ^ b;
      ALU_SRL:    result = a >> shamt;
      ALU_SRA:    result = $signed(a) >>> shamt;
      ALU_OR:     result = a | b;
      ALU_AND:    result = a & b;
      ALU_PASS_B: result = b;
      default:    result = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/riscv_multicycle_core.sv
// riscv_multicycle_core: FETCH/WAIT/EXEC/HALT RV32I-subset core top. Rev 1.0
// Optional retire trace ports: define RISCV_MULTICYCLE_CORE_RETIRE_TRACE_EN.
`default_nettype none

module riscv_multicycle_core
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clock,
  input  logic            reset,
  output logic            insn_req_valid,
  input  logic            insn_req_ready,
  output logic [XLEN-1:0] insn_addr_bus,
  input  logic            insn_rsp_valid,
  input  logic [31:0]     insn_data_bus,
  output logic            halted,
  output logic [1:0]      halt_cause
`ifdef RISCV_MULTICYCLE_CORE_RETIRE_TRACE_EN
  ,
  output logic            retire_valid,
  output logic [XLEN-1:0] retire_pc,
  output logic [4:0]      retire_rd,
  output logic [XLEN-1:0] retire_rd_data
`endif
);

  core_state_t     state, state_n;
  halt_cause_t     cause;
  logic [XLEN-1:0] pc;
  logic [31:0]     ir;
  logic [XLEN-1:0] rf [32];

  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [4:0]      rd, rs1, rs2;
  logic [XLEN-1:0] imm_i, imm_b, imm_j, imm_u;
  logic [XLEN-1:0] rs1_val, rs2_val, pc_plus4;

  alu_op_t         alu_op;
  logic [XLEN-1:0] alu_a, alu_b, alu_res;
  logic            alu_eq, alu_lt, alu_ltu;

  logic            wr_en, illegal, taken, misaligned, fault;
  logic [XLEN-1:0] wr_data, target, next_pc;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign funct3 = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign funct7 = ir[31:25];

  assign imm_i = {{(XLEN-12){ir[31]}}, ir[31:20]};
  assign imm_b = {{(XLEN-12){ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_j = {{(XLEN-20){ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
  assign imm_u = {{(XLEN-31){ir[31]}}, ir[30:12], 12'b0};

  assign rs1_val  = (rs1 == 5'd0) ? '0 : rf[rs1];
  assign rs2_val  = (rs2 == 5'd0) ? '0 : rf[rs2];
  assign pc_plus4 = pc + XLEN'(4);

  riscv_alu #(.XLEN(XLEN)) u_alu (
    .op     (alu_op),
    .a      (alu_a),
    .b      (alu_b),
    .result (alu_res),
    .eq     (alu_eq),
    .lt     (alu_lt),
    .ltu    (alu_ltu)
  );

  always_comb begin
    alu_op  = ALU_ADD;
    alu_a   = rs1_val;
    alu_b   = imm_i;
    wr_en   = 1'b0;
    wr_data = alu_res;
    illegal = 1'b0;
    taken   = 1'b0;
    target  = pc + imm_b;
    unique case (opcode)
      OPC_OP: begin
        alu_b   = rs2_val;
        alu_op  = alu_op_from_funct3(funct3, funct7[5]);
        wr_en   = 1'b1;
        illegal = !((funct7 == 7'b0000000) ||
                    (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)));
      end
      OPC_OP_IMM: begin
        alu_op = alu_op_from_funct3(funct3, (funct3 == 3'b101) && ir[30]);
        wr_en  = 1'b1;
        // ir[25] is shamt[5] on RV64 but must be zero on RV32
        if (funct3 == 3'b001)
          illegal = (ir[31:26] != 6'b000000) || (XLEN == 32 && ir[25]);
        else if (funct3 == 3'b101)
          illegal = (ir[31:26] != 6'b000000 && ir[31:26] != 6'b010000) ||
                    (XLEN == 32 && ir[25]);
      end
      OPC_LUI: begin
        alu_op = ALU_PASS_B;
        alu_b  = imm_u;
        wr_en  = 1'b1;
      end
      OPC_AUIPC: begin
        alu_a = pc;
        alu_b = imm_u;
        wr_en = 1'b1;
      end
      OPC_JAL: begin
        taken   = 1'b1;
        target  = pc + imm_j;
        wr_en   = 1'b1;
        wr_data = pc_plus4;
      end
      OPC_JALR: begin
        taken   = 1'b1;
        target  = alu_res & ~XLEN'(1);
        wr_en   = 1'b1;
        wr_data = pc_plus4;
      end
      OPC_BRANCH: begin
        alu_b = rs2_val;
        unique case (funct3)
          3'b000:  taken = alu_eq;
          3'b001:  taken = !alu_eq;
          3'b100:  taken = alu_lt;
          3'b101:  taken = !alu_lt;
          3'b110:  taken = alu_ltu;
          3'b111:  taken = !alu_ltu;
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

  assign misaligned = taken && target[1];
  assign fault      = illegal || misaligned;
  assign next_pc    = taken ? target : pc_plus4;

  always_ff @(posedge clock) begin
    if (reset) state <= FETCH;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      FETCH:   if (insn_req_ready) state_n = WAIT;
      WAIT:    if (insn_rsp_valid) state_n = EXEC;
      EXEC:    state_n = fault ? HALT : FETCH;
      default: state_n = HALT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc    <= RESET_PC;
      ir    <= '0;
      cause <= HC_NONE;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      if (state == WAIT && insn_rsp_valid) ir <= insn_data_bus;
      if (state == EXEC) begin
        // illegal takes priority: a bad opcode has no meaningful target
        if (illegal) begin
          cause <= HC_ILLEGAL;
        end else if (misaligned) begin
          cause <= HC_MISALIGNED;
        end else begin
          pc <= next_pc;
          if (wr_en && rd != 5'd0) rf[rd] <= wr_data;
        end
      end
    end
  end

  assign insn_req_valid = (state == FETCH);
  assign insn_addr_bus  = pc;
  assign halted         = (state == HALT);
  assign halt_cause     = cause;

`ifdef RISCV_MULTICYCLE_CORE_RETIRE_TRACE_EN
  assign retire_valid   = (state == EXEC) && !fault && !reset;
  assign retire_pc      = retire_valid ? pc : '0;
  assign retire_rd      = (retire_valid && wr_en) ? rd : 5'd0;
  assign retire_rd_data = (retire_valid && wr_en && rd != 5'd0) ? wr_data : '0;
`endif

endmodule

`default_nettype wire

// File: doc/riscv_multicycle_core.md
# riscv_multicycle_core

Multi-cycle RV32I-subset integer core: the next generation of the single-path core top. It adds a fetch handshake, a sequencing state machine, real register write-back, and control flow (branches and jumps). A shared ALU sub-module executes operations. The block is the CPU top, driving the instruction bus directly; loads, stores and CSRs are out of scope for this generation.

## Interface
- XLEN, 32: datapath and register width; legal values 32 and 64 (RV64 OP-32 forms not supported)
- RESET_PC, 'h0000_0000: PC value loaded on reset
- clock  input  1  sole clock, rising edge
- reset  input  1  synchronous, active-high; all state reset on the clock edge where it is high
- insn_req_valid  output  1  fetch request valid
- insn_req_ready  input  1  memory accepts request
- insn_addr_bus  output  XLEN  fetch address (current PC)
- insn_rsp_valid  input  1  instruction word valid
- insn_data_bus  input  32  instruction word
- halted  output  1  core stopped on illegal or misaligned condition
- halt_cause  output  2  0 none, 1 illegal insn, 2 misaligned target

## Operation
- States: FETCH, WAIT, EXEC, HALT. Reset state is FETCH, with PC=RESET_PC.
- FETCH:
  - insn_req_valid=1 and insn_addr_bus=PC.
  - On valid&&ready go to WAIT.
  - Valid and address held stable until accepted.
- WAIT:
  - insn_req_valid=0.
  - On insn_rsp_valid, latch the word into IR and go to EXEC.
  - insn_rsp_valid is ignored in every other state.
- EXEC:
  - Decode IR, read rs1/rs2 from the internal 32-entry register file, run the ALU.
  - Write rd unless rd==0; x0 always reads 0.
  - Update PC, then go to FETCH, or to HALT on a fault.
- Supported opcodes: OP, OP-IMM (all funct3/funct7 incl. SUB/SRA/SRAI), LUI, AUIPC, JAL, JALR, BRANCH (BEQ/BNE/BLT/BGE/BLTU/BGEU).
- Any other opcode, or an illegal funct7 for OP/shift-immediate, sets halt_cause=1 and enters HALT; no register write occurs.
- Next PC:
  - Default: PC+4.
  - Taken branch / JAL: PC+sext(imm).
  - JALR: (rs1+sext(imm)) & ~1.
- Target with bit1 set on taken branch/JAL/JALR: halt_cause=2, enter HALT, rd not written, PC unchanged.
- JAL/JALR link value is PC+4; it is written only when the jump is not faulting.
- Arithmetic:
  - Modulo 2^XLEN.
  - Shift amount is rs2[4:0] for XLEN=32 and rs2[5:0] for XLEN=64.
  - Immediates are sign-extended to XLEN.
  - LUI/AUIPC upper immediate is sign-extended from bit 31.
- HALT: absorbing. insn_req_valid=0, halted=1; exit only via reset.
- Register file is cleared to 0 on reset.

## Timing
- Reset values:
  - insn_req_valid=1 (state FETCH), insn_addr_bus=RESET_PC
  - halted=0, halt_cause=0
  - all registers 0
- Minimum 3 cycles per instruction: FETCH accept (1) + WAIT with rsp in the next cycle (1) + EXEC (1).
- Each cycle of insn_req_ready=0 or of missing response adds one cycle.
- Register write and PC update take effect on the clock edge ending EXEC. The next FETCH presents the new PC in the cycle after EXEC.
- Response in the same cycle as request acceptance is not accepted; the earliest response is sampled in WAIT.
- Reset mid-operation:
  - From any state, next state is FETCH with PC=RESET_PC.
  - An in-flight response arriving after reset is ignored, since the FSM is in FETCH.
  - Reset in EXEC suppresses that instruction's write-back.

## Configuration
- RISCV_MULTICYCLE_CORE_RETIRE_TRACE_EN defined:
  - Adds outputs retire_valid (1), retire_pc (XLEN), retire_rd (5), retire_rd_data (XLEN).
  - retire_valid pulses 1 for exactly the EXEC cycle of each non-faulting instruction.
  - retire_rd=0 when nothing is written.
  - All trace outputs are 0 on reset.
- Undefined: the ports do not exist and no trace logic is built. Core behaviour is identical either way.

## Structure
- Package riscv_pkg:
  - opcode constants (OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH)
  - alu_op_t enum
  - core_state_t enum {FETCH, WAIT, EXEC, HALT}
  - halt_cause_t
- Sub-module riscv_alu: combinational; inputs alu_op_t and two XLEN operands; outputs result and branch compare flags.
- Decode, the register file and the FSM live in the top module.

## Test plan
- ADDI x1,x0,5 (0x00500093) at RESET_PC, ready=1, rsp next cycle -> x1=5 after 3 cycles; second fetch address 0x4.
- ADDI x2,x0,-3 then ADD x3,x1,x2 (0x002081B3) -> x3=2; SUB variant -> x3=8. Write to x0 leaves x0 reading 0.
- BEQ x0,x0,+8 (0x00000463) at 0x8 -> next fetch 0x10. BNE x0,x0,+8 -> next fetch 0xC.
- JAL x1,+8 (0x008000EF) at 0x0 -> x1=4, next fetch 0x8. JALR to odd address +1 -> bit0 cleared. Target with bit1 set -> halted=1, halt_cause=2.
- Word 0x00000000 -> halted=1, halt_cause=1, insn_req_valid=0 thereafter. Reset -> FETCH at RESET_PC.
- Ready held low for 4 cycles with an address change attempted -> address stable, instruction completes 4 cycles later. Reset asserted during WAIT, then late rsp -> ignored, fetch restarts at RESET_PC.
